// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types: state width, byte count, state type and the
// InvSubBytes sequencer FSM encoding (DRAIN exists only with SBOX_PIPE_EN).
package aes_dec_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef logic [AES_STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SUB,
    SEQ_DONE
`ifdef SBOX_PIPE_EN
    , SEQ_DRAIN
`endif
  } seq_state_t;

  // Byte 0 is the most significant byte, so byte pos starts at bit 8*(15-pos).
  function automatic logic [6:0] byte_lsb(input logic [3:0] pos);
    return {~pos, 3'b000};
  endfunction

  function automatic logic [7:0] get_byte(input state_t s, input logic [3:0] pos);
    return s[byte_lsb(pos) +: 8];
  endfunction

endpackage

// File: rtl/inv_sbox_lane.sv
// Combinational FIPS-197 inverse S-box for one byte, held as a flat
// 256-entry table with entry 0 in the most significant byte.
module inv_sbox_lane (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
    128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e,
    128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692,
    128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
    128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
    128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
    128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f,
    128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
    128'h172b047e_ba77d626_e1691463_55210c7d
  };

  logic [10:0] w_lsb;

  assign w_lsb  = {~i_byte, 3'b000};
  assign o_byte = INV_SBOX_TBL[w_lsb +: 8];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential InvSubBytes: LANES inverse S-box lookups walk the 16 state bytes.
// Define SBOX_PIPE_EN to register the lookups (adds a DRAIN cycle).
module inv_sub_bytes_seq
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam logic [4:0] STEP = 5'(LANES);

  seq_state_t r_state;
  seq_state_t w_state_nxt;
  logic [4:0] r_idx;
  logic [4:0] w_idx_nxt;
  state_t     r_in;
  state_t     r_out;
  logic       w_accept;
  logic       w_last;
  logic       w_wr_en;
  logic [3:0] w_wr_pos;
  logic [7:0] w_lane_in  [LANES];
  logic [7:0] w_lane_out [LANES];
  logic [7:0] w_wr_byte  [LANES];
  logic [6:0] w_wr_lsb   [LANES];

  assign in_ready  = (r_state == SEQ_IDLE) && !clear;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == SEQ_DONE);
  assign busy      = (r_state != SEQ_IDLE);
  assign out_state = r_out;
  assign w_last    = ((r_idx + STEP) == 5'd16);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_in[i] = get_byte(r_in, r_idx[3:0] + 4'(i));
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    inv_sbox_lane u_lane (
      .i_byte (w_lane_in[gi]),
      .o_byte (w_lane_out[gi])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      SEQ_IDLE: begin
        if (w_accept) begin
          w_state_nxt = SEQ_SUB;
          w_idx_nxt   = 5'd0;
        end
      end
      SEQ_SUB: begin
        w_idx_nxt = w_last ? 5'd0 : (r_idx + STEP);
        if (w_last) begin
`ifdef SBOX_PIPE_EN
          w_state_nxt = SEQ_DRAIN;
`else
          w_state_nxt = SEQ_DONE;
`endif
        end
      end
`ifdef SBOX_PIPE_EN
      SEQ_DRAIN: w_state_nxt = SEQ_DONE;
`endif
      SEQ_DONE: begin
        if (out_ready) begin
          w_state_nxt = SEQ_IDLE;
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
    // Abort outranks every other transition.
    if (clear) begin
      w_state_nxt = SEQ_IDLE;
      w_idx_nxt   = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
      r_idx   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_in <= in_state;
    end
  end

`ifdef SBOX_PIPE_EN
  logic [7:0] r_pipe_byte [LANES];
  logic [3:0] r_pipe_pos;
  logic       r_pipe_vld;

  // Stage boundary: lookup results held one cycle before the result write.
  always_ff @(posedge clk) begin
    if (r_state == SEQ_SUB) begin
      r_pipe_byte <= w_lane_out;
      r_pipe_pos  <= r_idx[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= 1'b0;
    end else begin
      r_pipe_vld <= (r_state == SEQ_SUB) && !clear;
    end
  end

  assign w_wr_en  = r_pipe_vld && !clear;
  assign w_wr_pos = r_pipe_pos;
  assign w_wr_byte = r_pipe_byte;
`else
  assign w_wr_en  = (r_state == SEQ_SUB) && !clear;
  assign w_wr_pos = r_idx[3:0];
  assign w_wr_byte = w_lane_out;
`endif

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_wr_lsb[i] = byte_lsb(w_wr_pos + 4'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        r_out[w_wr_lsb[i] +: 8] <= w_wr_byte[i];
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomized bench for inv_sub_bytes_seq: one instance per legal LANES value,
// all checked against an inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_seq;

  localparam int NDUT = 5;
`ifdef SBOX_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] in_state = '0;
  logic         in_ready_a  [NDUT];
  logic         out_valid_a [NDUT];
  logic         busy_a      [NDUT];
  logic [127:0] out_state_a [NDUT];
  logic [127:0] cap         [NDUT];
  logic [7:0]   inv_tbl     [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[g]),
      .in_state  (in_state),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready),
      .out_state (out_state_a[g]),
      .busy      (busy_a[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_out(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      r[127-8*k -: 8] = inv_tbl[st[127-8*k -: 8]];
    end
    return r;
  endfunction

  function automatic int lat_exp(input int g);
    return (16 >> g) + PIPE;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input logic [127:0] st);
    logic [127:0] expv;
    bit           seen [NDUT];
    int           lat  [NDUT];
    bit           all_seen;
    expv = model_out(st);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (in_ready_a[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL op_ready lanes=%0d got=%b exp=1", 1 << g, in_ready_a[g]);
      end
      seen[g] = 1'b0;
      lat[g]  = 0;
    end
    in_valid = 1'b1;
    in_state = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rnd128();
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      in_state = rnd128();
      for (int g = 0; g < NDUT; g++) begin
        if (!seen[g] && out_valid_a[g] === 1'b1) begin
          seen[g] = 1'b1;
          lat[g]  = cyc;
          cap[g]  = out_state_a[g];
          n_tests++;
          if (out_state_a[g] !== expv) begin
            n_fail++;
            $display("FAIL op_data lanes=%0d got=%h exp=%h", 1 << g, out_state_a[g], expv);
          end
        end
      end
      all_seen = 1'b1;
      for (int g = 0; g < NDUT; g++) if (!seen[g]) all_seen = 1'b0;
      if (all_seen) break;
    end
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (!seen[g]) begin
        n_fail++;
        $display("FAIL op_timeout lanes=%0d got=no out_valid exp=out_valid", 1 << g);
      end else if (lat[g] != lat_exp(g)) begin
        n_fail++;
        $display("FAIL op_latency lanes=%0d got=%0d exp=%0d", 1 << g, lat[g], lat_exp(g));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (out_valid_a[g] !== 1'b0 || busy_a[g] !== 1'b0 || out_state_a[g] !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs lanes=%0d got=v%b b%b %h exp=v0 b0 0", 1 << g,
                 out_valid_a[g], busy_a[g], out_state_a[g]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (in_ready_a[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_in_ready lanes=%0d got=%b exp=1", 1 << g, in_ready_a[g]);
      end
    end
  endtask

  task automatic test_basic();
    run_op({16{8'h63}});
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (cap[g] !== 128'h0) begin
        n_fail++;
        $display("FAIL basic_63 lanes=%0d got=%h exp=0", 1 << g, cap[g]);
      end
    end
  endtask

  task automatic test_vector();
    logic [95:0] tail;
    tail = 96'(rnd128());
    run_op({32'h007cff63, tail});
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (cap[g][127:96] !== 32'h52017d00) begin
        n_fail++;
        $display("FAIL vector_head lanes=%0d got=%h exp=52017d00", 1 << g, cap[g][127:96]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [7:0]   r8;
    logic [127:0] st;
    r8 = 8'($urandom);
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) st[127-8*k -: 8] = 8'(16*j + k) ^ r8;
      run_op(st);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) run_op(rnd128());
  endtask

  task automatic test_backpressure();
    logic [127:0] st, expv;
    bit           all_v;
    st   = rnd128();
    expv = model_out(st);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = st;
    @(posedge clk); #1;
    in_valid = 1'b0;
    all_v    = 1'b0;
    for (int cyc = 0; cyc < 40 && !all_v; cyc++) begin
      @(posedge clk); #1;
      in_state = rnd128();
      all_v = 1'b1;
      for (int g = 0; g < NDUT; g++) if (out_valid_a[g] !== 1'b1) all_v = 1'b0;
    end
    n_tests++;
    if (!all_v) begin
      n_fail++;
      $display("FAIL bp_timeout got=not all valid exp=all valid");
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_state = rnd128();
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++) begin
        n_tests++;
        if (out_valid_a[g] !== 1'b1 || out_state_a[g] !== expv || in_ready_a[g] !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_hold lanes=%0d got=v%b r%b %h exp=v1 r0 %h", 1 << g,
                   out_valid_a[g], in_ready_a[g], out_state_a[g], expv);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (out_valid_a[g] !== 1'b0 || in_ready_a[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_release lanes=%0d got=v%b r%b exp=v0 r1", 1 << g,
                 out_valid_a[g], in_ready_a[g]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (busy_a[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_no_accept lanes=%0d got=busy %b exp=0", 1 << g, busy_a[g]);
      end
    end
  endtask

  task automatic test_clear();
    bit saw [NDUT];
    @(negedge clk);
    in_valid = 1'b1;
    in_state = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (busy_a[g] !== 1'b0 || out_valid_a[g] !== 1'b0 || in_ready_a[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_abort lanes=%0d got=b%b v%b r%b exp=b0 v0 r0", 1 << g,
                 busy_a[g], out_valid_a[g], in_ready_a[g]);
      end
    end
    in_valid = 1'b1;
    in_state = rnd128();
    @(posedge clk); #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (busy_a[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_blocks_accept lanes=%0d got=busy %b exp=0", 1 << g, busy_a[g]);
      end
      saw[g] = 1'b0;
    end
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++) if (out_valid_a[g] === 1'b1) saw[g] = 1'b1;
    end
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (saw[g]) begin
        n_fail++;
        $display("FAIL clear_no_valid lanes=%0d got=out_valid pulse exp=none", 1 << g);
      end
    end
    run_op({16{8'h00}});
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (cap[g] !== {16{8'h52}}) begin
        n_fail++;
        $display("FAIL clear_then_zero lanes=%0d got=%h exp=52..52", 1 << g, cap[g]);
      end
    end
  endtask

  task automatic test_async_reset();
    bit saw [NDUT];
    @(negedge clk);
    in_valid = 1'b1;
    in_state = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (out_valid_a[g] !== 1'b0 || busy_a[g] !== 1'b0 || out_state_a[g] !== '0) begin
        n_fail++;
        $display("FAIL areset_outputs lanes=%0d got=v%b b%b %h exp=v0 b0 0", 1 << g,
                 out_valid_a[g], busy_a[g], out_state_a[g]);
      end
      saw[g] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      for (int g = 0; g < NDUT; g++) if (out_valid_a[g] === 1'b1) saw[g] = 1'b1;
    end
    for (int g = 0; g < NDUT; g++) begin
      n_tests++;
      if (saw[g] || in_ready_a[g] !== 1'b1) begin
        n_fail++;
        $display("FAIL areset_discard lanes=%0d got=pulse %b ready %b exp=pulse 0 ready 1",
                 1 << g, saw[g], in_ready_a[g]);
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) inv_tbl[fwd_sbox(8'(x))] = 8'(x);
    test_reset();
    test_basic();
    test_vector();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=no finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
